// File: rtl/proc_pkg.sv
// Shared definitions for the program fetch unit.
// Holds bus widths, the reset PC, the fetch FSM states and the long-opcode test.
package proc_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        HOLD   = 2'd2
    } fetch_state_t;

    // Bit 7 of an instruction's first byte marks a two-byte instruction.
    function automatic logic is_long(input logic [DATA_W-1:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register with synchronous reset, load and increment.
// Ports: clock, reset, ld/target (load, wins over inc), inc (+1 mod 2^ADDR_W), q.
module pc_counter #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (ld) begin
            r_pc <= target;
        end else if (inc) begin
            // Natural wrap: 0xFFF + 1 -> 0x000.
            r_pc <= r_pc + 1'b1;
        end
    end

    assign q = r_pc;

endmodule

// File: rtl/program_fetch.sv
// Program fetch: reads the async ROM at pc, assembles 1/2-byte instructions.
// Ports: clock/reset, pc/program_byte (ROM), ld_pc/pc_target (redirect), instr_* (valid/ready out).
module program_fetch #(
    parameter int                ADDR_W   = proc_pkg::ADDR_W,
    parameter int                DATA_W   = proc_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] program_byte,
    input  logic              ld_pc,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_byte0,
    output logic [DATA_W-1:0] instr_byte1,
    output logic              instr_long,
    output logic [ADDR_W-1:0] instr_pc
);

    import proc_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic              w_inc;
    logic              w_cap0;
    logic              w_cap1;
    logic [ADDR_W-1:0] w_pc;

    logic              r_valid;
    logic [DATA_W-1:0] r_byte0;
    logic [DATA_W-1:0] r_byte1;
    logic              r_long;
    logic [ADDR_W-1:0] r_ipc;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock  (clock),
        .reset  (reset),
        .ld     (ld_pc),
        .target (pc_target),
        .inc    (w_inc),
        .q      (w_pc)
    );

    // A redirect abandons whatever is in flight, including a held
    // instruction that is being handshaken on the same edge.
    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        w_cap0 = 1'b0;
        w_cap1 = 1'b0;
        if (ld_pc) begin
            w_next = FETCH1;
        end else begin
            case (r_state)
                FETCH1: begin
                    w_inc  = 1'b1;
                    w_cap0 = 1'b1;
                    w_next = is_long(program_byte) ? FETCH2 : HOLD;
                end
                FETCH2: begin
                    w_inc  = 1'b1;
                    w_cap1 = 1'b1;
                    w_next = HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        w_next = FETCH1;
                    end
                end
                default: begin
                    w_next = FETCH1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FETCH1;
            r_valid <= 1'b0;
            r_byte0 <= '0;
            r_byte1 <= '0;
            r_long  <= 1'b0;
            r_ipc   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == HOLD);
            if (w_cap0) begin
                r_byte0 <= program_byte;
                r_byte1 <= '0;
                r_long  <= is_long(program_byte);
                r_ipc   <= w_pc;
            end
            if (w_cap1) begin
                r_byte1 <= program_byte;
            end
        end
    end

    assign pc          = w_pc;
    assign instr_valid = r_valid;
    assign instr_byte0 = r_byte0;
    assign instr_byte1 = r_byte1;
    assign instr_long  = r_long;
    assign instr_pc    = r_ipc;

endmodule

// File: tb/tb_program_fetch.sv
// Directed testbench for program_fetch with a behavioural async-read ROM.
// Observed vector: {valid, long, byte0, byte1, instr_pc, pc}.
module tb_program_fetch;

    logic        clock;
    logic        reset;
    logic [11:0] pc;
    logic [7:0]  program_byte;
    logic        ld_pc;
    logic [11:0] pc_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_byte0;
    logic [7:0]  instr_byte1;
    logic        instr_long;
    logic [11:0] instr_pc;

    logic [7:0]  rom [0:4095];
    int          checks;
    int          errors;
    logic [41:0] obs;
    logic [41:0] exp_v;

    program_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .program_byte (program_byte),
        .ld_pc        (ld_pc),
        .pc_target    (pc_target),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_byte0  (instr_byte0),
        .instr_byte1  (instr_byte1),
        .instr_long   (instr_long),
        .instr_pc     (instr_pc)
    );

    assign program_byte = rom[pc];
    assign obs = {instr_valid, instr_long, instr_byte0, instr_byte1, instr_pc, pc};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        // now holding a fetched instruction; reset again for 3 cycles
        reset = 1'b1;
        tick();
        tick();
        tick();
        exp_v = {1'b0, 1'b0, 8'h00, 8'h00, 12'h000, 12'h000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_short();
        instr_ready = 1'b1;
        tick();
        exp_v = {1'b1, 1'b0, 8'h35, 8'h00, 12'h000, 12'h001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL short_first: got %h expected %h", obs, exp_v);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h001) begin
            errors++;
            $display("FAIL short_handshake: got valid=%b pc=%h expected valid=0 pc=001",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b0, 8'h07, 8'h00, 12'h001, 12'h002};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL short_second: got %h expected %h", obs, exp_v);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_long();
        ld_pc = 1'b1;
        pc_target = 12'h010;
        tick();
        ld_pc = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h010) begin
            errors++;
            $display("FAIL long_redirect: got valid=%b pc=%h expected valid=0 pc=010",
                     instr_valid, pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h011) begin
            errors++;
            $display("FAIL long_fetch2: got valid=%b pc=%h expected valid=0 pc=011",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b1, 8'h8A, 8'hBC, 12'h010, 12'h012};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL long_instr: got %h expected %h", obs, exp_v);
        end
        checks++;
        if ({instr_byte0[3:0], instr_byte1} !== 12'hABC) begin
            errors++;
            $display("FAIL long_target: got %h expected abc",
                     {instr_byte0[3:0], instr_byte1});
        end
    endtask

    task automatic test_backpressure();
        exp_v = {1'b1, 1'b1, 8'h8A, 8'hBC, 12'h010, 12'h012};
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h012) begin
            errors++;
            $display("FAIL backpressure_release: got valid=%b pc=%h expected valid=0 pc=012",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b0, 8'h00, 8'h00, 12'h012, 12'h013};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL backpressure_next: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_redirect_mid_long();
        ld_pc = 1'b1;
        pc_target = 12'h020;
        tick();
        ld_pc = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h021) begin
            errors++;
            $display("FAIL midlong_fetch2: got valid=%b pc=%h expected valid=0 pc=021",
                     instr_valid, pc);
        end
        ld_pc = 1'b1;
        pc_target = 12'h400;
        tick();
        ld_pc = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h400) begin
            errors++;
            $display("FAIL midlong_drop: got valid=%b pc=%h expected valid=0 pc=400",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b0, 8'h4F, 8'h00, 12'h400, 12'h401};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL midlong_next: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_wrap();
        ld_pc = 1'b1;
        pc_target = 12'hFFF;
        tick();
        ld_pc = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h000) begin
            errors++;
            $display("FAIL wrap_pc: got valid=%b pc=%h expected valid=0 pc=000",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b1, 8'h91, 8'h22, 12'hFFF, 12'h001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL wrap_instr: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_ld_with_handshake();
        instr_ready = 1'b1;
        ld_pc = 1'b1;
        pc_target = 12'h030;
        tick();
        ld_pc = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h030) begin
            errors++;
            $display("FAIL ld_hs_redirect: got valid=%b pc=%h expected valid=0 pc=030",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b0, 8'h12, 8'h00, 12'h030, 12'h031};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL ld_hs_next: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        // ready held high: short then long, cadence 2 and 3 cycles
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap0: got valid=%b expected 0", instr_valid);
        end
        tick();
        exp_v = {1'b1, 1'b0, 8'h13, 8'h00, 12'h031, 12'h032};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_short: got %h expected %h", obs, exp_v);
        end
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 12'h033) begin
            errors++;
            $display("FAIL b2b_gap1: got valid=%b pc=%h expected valid=0 pc=033",
                     instr_valid, pc);
        end
        tick();
        exp_v = {1'b1, 1'b1, 8'h84, 8'h56, 12'h032, 12'h034};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_long: got %h expected %h", obs, exp_v);
        end
        instr_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
        rom[12'h000] = 8'h35;
        rom[12'h001] = 8'h07;
        rom[12'h010] = 8'h8A;
        rom[12'h011] = 8'hBC;
        rom[12'h020] = 8'hC1;
        rom[12'h021] = 8'h55;
        rom[12'h400] = 8'h4F;
        rom[12'hFFF] = 8'h91;
        rom[12'h030] = 8'h12;
        rom[12'h031] = 8'h13;
        rom[12'h032] = 8'h84;
        rom[12'h033] = 8'h56;
        reset = 1'b1;
        ld_pc = 1'b0;
        pc_target = 12'h000;
        instr_ready = 1'b0;

        test_reset();
        test_short();
        test_long();
        test_backpressure();
        test_redirect_mid_long();
        rom[12'h000] = 8'h22;
        test_wrap();
        test_ld_with_handshake();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_fetch.md
Name: program_fetch

Overview:
- Initiator side of the program-memory interface: drives the 12-bit PC into the 4K×8 asynchronous-read program ROM and consumes the returned program_byte.
- Assembles 1-byte (short) or 2-byte (long) instructions and presents them to the decode/execute stage with a valid/ready handshake.
- Accepts PC redirects (jumps, branches) from execute.

Parameters:
- ADDR_W, 12, PC / ROM address width.
- DATA_W, 8, program byte width.
- RESET_PC, 12'h000, PC value after reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  out  ADDR_W  address to ROM; ROM returns program_byte combinationally in the same cycle.
- program_byte  in  DATA_W  byte read from ROM at pc.
- ld_pc  in  1  redirect request from execute.
- pc_target  in  ADDR_W  redirect address; sampled when ld_pc=1.
- instr_valid  out  1  instruction registers hold a complete instruction.
- instr_ready  in  1  downstream accepts the instruction.
- instr_byte0  out  DATA_W  first byte; [7:4] opcode, [3:0] nibble operand.
- instr_byte1  out  DATA_W  second byte (long only); 0 for short.
- instr_long  out  1  1 = two-byte instruction.
- instr_pc  out  ADDR_W  address of instr_byte0.

Behaviour:
- Long-instruction rule: program_byte[7]=1 in the first byte. Long target/immediate is {instr_byte0[3:0], instr_byte1}.
- States:
  - FETCH1: capture program_byte into instr_byte0, capture pc into instr_pc, then pc <= pc+1. If the byte is long, go to FETCH2; otherwise set instr_byte1=0 and go to HOLD.
  - FETCH2: capture program_byte into instr_byte1, then pc <= pc+1, then go to HOLD.
  - HOLD: instr_valid=1. Handshake is instr_valid & instr_ready at a rising edge; on handshake go to FETCH1. Otherwise stay; all instr_* and pc are stable.
- instr_valid is a registered output, asserted only in HOLD.
- Latency: short instruction valid 1 cycle after entering FETCH1; long instruction valid 2 cycles after. Throughput with ready tied high: short every 2 cycles, long every 3 cycles.
- Redirect: ld_pc=1 in any state sets pc <= pc_target and state <= FETCH1.
  - Any partially fetched or held instruction is discarded; instr_valid=0 the next cycle.
  - If the handshake and ld_pc occur in the same cycle, the held instruction counts as consumed.
- Priority: reset > ld_pc > handshake / normal sequencing.
- PC wrap: pc+1 is mod 2^ADDR_W, so 0xFFF -> 0x000. A long instruction at 0xFFF takes its second byte from 0x000.
- Reset state: pc=RESET_PC, state=FETCH1, instr_valid=0, instr_byte0=0, instr_byte1=0, instr_long=0, instr_pc=0.
  - Reset asserted mid-fetch or mid-HOLD overrides everything on that edge.
  - The first fetch starts on the first cycle after reset deasserts.
- No X propagation: the state register has a default arm returning to FETCH1.

Decomposition:
- Shared package (proc_pkg):
  - ADDR_W / DATA_W constants.
  - fetch_state_t enum {FETCH1, FETCH2, HOLD}.
  - is_long(byte) function, returning byte[7].
  - RESET_PC default.
- One sub-module, pc_counter: ADDR_W register with synchronous reset, load (ld, target) and increment (inc) inputs, load priority over increment. The FSM in program_fetch drives inc/ld.

Test Plan:
- Reset: assert reset 3 cycles mid-fetch -> pc=0x000, instr_valid=0, all instr_* = 0; after release, pc advances to 0x001 after 1 cycle.
- Short fetch: ROM[0x000]=0x35, ready=1 -> instr_valid=1 one cycle after reset release with byte0=0x35, long=0, byte1=0x00, instr_pc=0x000, pc=0x001. Handshake, then next fetch from 0x001.
- Long fetch: ROM[0x010]=0x8A, ROM[0x011]=0xBC, ld_pc with target 0x010 -> valid after 2 cycles with long=1, byte0=0x8A, byte1=0xBC, target nibble/byte = 0xABC, pc=0x012.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr_* and pc unchanged. Ready=1 for one cycle -> next cycle state is FETCH1 and instr_valid=0.
- Redirect mid-long: ld_pc=1 with pc_target=0x400 during FETCH2 -> pc=0x400, the partial instruction is dropped (no valid pulse), and the next valid instruction has instr_pc=0x400.
- Wrap: ROM[0xFFF]=0x91, ROM[0x000]=0x22, redirect to 0xFFF -> long instruction with byte1=0x22, instr_pc=0xFFF, pc=0x001 after completion.
